// File: rtl/prbs_checker_multi.sv
// rtl/prbs_checker_multi.sv - PRBS7/15/23/31 checker with self-synchronising lock FSM and error counters
module prbs_checker_multi #(
    parameter int CNT_W      = 32,
    parameter int LOCK_CNT   = 32,
    parameter int WIN_BITS   = 1024,
    parameter int ERR_THRESH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             data_in,
    input  logic             data_in_valid,
    input  logic [1:0]       poly_sel,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             lost_lock,
    output logic             err_out,
    output logic [CNT_W-1:0] total_bits,
    output logic [CNT_W-1:0] total_bit_errors
);
    localparam int WB_W = $clog2(WIN_BITS + 1);
    localparam int WE_W = $clog2(ERR_THRESH + 1);
    localparam logic [7:0]      LOCK_LAST = 8'(LOCK_CNT - 1);
    localparam logic [WB_W-1:0] WIN_LAST  = WB_W'(WIN_BITS - 1);
    localparam logic [WE_W-1:0] ERR_LIM   = WE_W'(ERR_THRESH);

    typedef enum logic [1:0] {SEED, CHECK, LOCKED} state_t;

    state_t            state_q, state_d;
    logic [30:0]       hist_q, hist_d;
    logic [4:0]        seed_q, seed_d;
    logic [7:0]        good_q, good_d;
    logic [WB_W-1:0]   win_q, win_d;
    logic [WE_W-1:0]   werr_q, werr_d, werr_inc;
    logic [1:0]        poly_q;
    logic [CNT_W-1:0]  tbits_q, tbits_d, terr_q, terr_d;
    logic              err_q, err_d, lost_q, lost_d;
    logic [4:0]        ord_m1, tap_m1;
    logic              pred, mism;

    always_ff @(posedge clk) begin
        poly_q <= poly_sel;
        if (rst) begin
            state_q <= SEED;
            hist_q  <= '0;
            seed_q  <= '0;
            good_q  <= '0;
            win_q   <= '0;
            werr_q  <= '0;
            tbits_q <= '0;
            terr_q  <= '0;
            err_q   <= 1'b0;
            lost_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            seed_q  <= seed_d;
            good_q  <= good_d;
            win_q   <= win_d;
            werr_q  <= werr_d;
            tbits_q <= tbits_d;
            terr_q  <= terr_d;
            err_q   <= err_d;
            lost_q  <= lost_d;
        end
    end

    always_comb begin
        case (poly_sel)
            2'd0:    begin ord_m1 = 5'd6;  tap_m1 = 5'd5;  end
            2'd1:    begin ord_m1 = 5'd14; tap_m1 = 5'd13; end
            2'd2:    begin ord_m1 = 5'd22; tap_m1 = 5'd17; end
            default: begin ord_m1 = 5'd30; tap_m1 = 5'd27; end
        endcase
        pred     = hist_q[ord_m1] ^ hist_q[tap_m1];
        mism     = data_in ^ pred;
        werr_inc = werr_q + WE_W'(mism);

        state_d = state_q;
        hist_d  = hist_q;
        seed_d  = seed_q;
        good_d  = good_q;
        win_d   = win_q;
        werr_d  = werr_q;
        err_d   = 1'b0;
        lost_d  = 1'b0;
        tbits_d = clr_cnt ? '0 : tbits_q;
        terr_d  = clr_cnt ? '0 : terr_q;

        if (poly_sel != poly_q) begin
            lost_d  = (state_q == LOCKED);
            state_d = SEED;
            seed_d  = '0;
        end else if (data_in_valid) begin
            case (state_q)
                SEED: begin
                    hist_d = {hist_q[29:0], data_in};
                    if (seed_q == ord_m1) begin
                        state_d = CHECK;
                        seed_d  = '0;
                        good_d  = '0;
                    end else begin
                        seed_d = seed_q + 5'd1;
                    end
                end
                CHECK: begin
                    hist_d = {hist_q[29:0], data_in};
                    if (mism) begin
                        state_d = SEED;
                        seed_d  = '0;
                    end else if (good_q == LOCK_LAST) begin
                        state_d = LOCKED;
                        win_d   = '0;
                        werr_d  = '0;
                    end else begin
                        good_d = good_q + 8'd1;
                    end
                end
                LOCKED: begin
                    // Feed back the prediction so a single channel error counts once.
                    hist_d = {hist_q[29:0], pred};
                    if (!(&tbits_d)) tbits_d = tbits_d + 1'b1;
                    if (mism) begin
                        err_d = 1'b1;
                        if (!(&terr_d)) terr_d = terr_d + 1'b1;
                    end
                    if (werr_inc == ERR_LIM) begin
                        state_d = SEED;
                        seed_d  = '0;
                        lost_d  = 1'b1;
                    end else if (win_q == WIN_LAST) begin
                        win_d  = '0;
                        werr_d = '0;
                    end else begin
                        win_d  = win_q + 1'b1;
                        werr_d = werr_inc;
                    end
                end
                default: state_d = SEED;
            endcase
        end
    end

    assign locked           = (state_q == LOCKED);
    assign lost_lock        = lost_q;
    assign err_out          = err_q;
    assign total_bits       = tbits_q;
    assign total_bit_errors = terr_q;
endmodule
